// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, latency defaults and state type for the HI/LO unit.
// Imported by the EX-stage multiply/divide logic and the decoder.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit with modelled multi-cycle latency.
// Optional macro MDU_MADD_EN adds signed madd/msub accumulation.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic               go;
  logic               launch;
  logic [63:0]        mul_s;
  logic [63:0]        mul_u;
  logic               b_zero;
  logic               div_ovf;
  logic signed [31:0] sa;
  logic signed [31:0] sb_safe;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        ub_safe;
  logic [31:0]        uq;
  logic [31:0]        ur;
`ifdef MDU_MADD_EN
  logic [63:0]        acc_add;
  logic [63:0]        acc_sub;
`endif

  // Combinational arithmetic; divisors are made safe so no trap path exists
  always_comb begin
    mul_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mul_u   = {32'd0, a} * {32'd0, b};
    b_zero  = (b == 32'd0);
    div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sa      = $signed(a);
    sb_safe = (b_zero || div_ovf) ? 32'sd1 : $signed(b);
    ub_safe = b_zero ? 32'd1 : b;
    sq      = sa / sb_safe;
    sr      = sa % sb_safe;
    uq      = a / ub_safe;
    ur      = a % ub_safe;
`ifdef MDU_MADD_EN
    acc_add = {hi_q, lo_q} + mul_s;
    acc_sub = {hi_q, lo_q} - mul_s;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: launch into BUSY, leave on the last count
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && launch) state_d = S_BUSY;
    if (state_q == S_BUSY && cnt_q == CNT_W'(1)) state_d = S_IDLE;
  end

  // Output decode
  always_comb begin
    busy = (state_q == S_BUSY);
    hi   = hi_q;
    lo   = lo_q;
  end

  // Op decode, pending result capture, countdown and HI/LO commit
  always_comb begin
    go        = start && !cancel && (state_q == S_IDLE);
    launch    = 1'b0;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (go) begin
      unique case (1'b1)
        (md_op == MD_MULT): begin
          launch = 1'b1;
          cnt_d  = CNT_W'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = mul_s;
          pend_we_d = 1'b1;
        end
        (md_op == MD_MULTU): begin
          launch = 1'b1;
          cnt_d  = CNT_W'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = mul_u;
          pend_we_d = 1'b1;
        end
        (md_op == MD_DIV): begin
          launch    = 1'b1;
          cnt_d     = CNT_W'(DIV_CYCLES);
          pend_hi_d = div_ovf ? 32'd0 : sr;
          pend_lo_d = div_ovf ? a : sq;
          pend_we_d = !b_zero;
        end
        (md_op == MD_DIVU): begin
          launch    = 1'b1;
          cnt_d     = CNT_W'(DIV_CYCLES);
          pend_hi_d = ur;
          pend_lo_d = uq;
          pend_we_d = !b_zero;
        end
        (md_op == MD_MTHI): hi_d = a;
        (md_op == MD_MTLO): lo_d = a;
`ifdef MDU_MADD_EN
        (md_op == MD_MADD): begin
          launch = 1'b1;
          cnt_d  = CNT_W'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = acc_add;
          pend_we_d = 1'b1;
        end
        (md_op == MD_MSUB): begin
          launch = 1'b1;
          cnt_d  = CNT_W'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = acc_sub;
          pend_we_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end else if (state_q == S_BUSY) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d = '0;
        if (pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule
